// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types and helpers for the LC-3b next-level memory arbiter.
//   lc3b_arb_state : arbiter sequencing states
//   lc3b_arb_mode  : channel selection policy (round-robin or fixed priority)
//   grant_width()  : bits needed to index NCH channels, never less than 1
package lc3b_mem_arbiter_pkg;

    localparam int unsigned LC3B_LINE_W = 128;
    localparam int unsigned LC3B_ADDR_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } lc3b_arb_mode;

    function automatic int unsigned grant_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/lc3b_rr_picker.sv
// Combinational channel picker shared by the memory arbiter and future
// multi-port write buffers.
//   req        : per-channel request vector
//   last_grant : most recently served channel (round-robin origin)
//   mode       : ARB_RR searches last_grant+1 .. last_grant+NCH modulo NCH,
//                ARB_FIXED picks the lowest-indexed requester
//   grant_c    : selected channel index
//   any_c      : at least one channel is requesting
module lc3b_rr_picker
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int unsigned NCH = 2
) (
    input  logic [NCH-1:0]              req,
    input  logic [grant_width(NCH)-1:0] last_grant,
    input  lc3b_arb_mode                mode,
    output logic [grant_width(NCH)-1:0] grant_c,
    output logic                        any_c
);

    localparam int unsigned GW = grant_width(NCH);

    logic [GW-1:0] idx;

    // Walk the search order from its far end so the nearest requester is written last.
    always_comb begin
        grant_c = '0;
        any_c   = 1'b0;
        idx     = '0;
        for (int unsigned k = NCH; k > 0; k--) begin
            if (mode == ARB_FIXED) begin
                idx = GW'(k - 1);
            end else begin
                idx = GW'((32'(last_grant) + k) % NCH);
            end
            if (req[idx]) begin
                grant_c = idx;
                any_c   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// N-channel cache-line arbiter in front of the shared L2 / physical memory port.
//   clk, reset            : clock, asynchronous active-high reset
//   req_read/req_write    : per-channel line requests (write wins if both set)
//   req_addr/req_wdata    : per-channel address and write line, held until resp
//   resp, resp_rdata      : one-cycle one-hot completion and read line
//   mem_read/mem_write    : registered downstream strobes
//   mem_address/mem_wdata : registered downstream address and write line
//   mem_rdata, mem_resp   : downstream read line and completion
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int unsigned  NCH    = 2,
    parameter int unsigned  LINE_W = LC3B_LINE_W,
    parameter int unsigned  ADDR_W = LC3B_ADDR_W,
    parameter lc3b_arb_mode MODE   = ARB_RR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH-1:0]             req_read,
    input  logic [NCH-1:0]             req_write,
    input  logic [NCH-1:0][ADDR_W-1:0] req_addr,
    input  logic [NCH-1:0][LINE_W-1:0] req_wdata,
    output logic [NCH-1:0]             resp,
    output logic [LINE_W-1:0]          resp_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic [LINE_W-1:0]          mem_rdata,
    input  logic                       mem_resp
);

    localparam int unsigned GW = grant_width(NCH);

    lc3b_arb_state     state_q;
    lc3b_arb_state     state_d;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     grant_d;
    logic [GW-1:0]     last_grant_q;
    logic [GW-1:0]     last_grant_d;
    logic [GW-1:0]     pick_grant;
    logic              pick_any;
    logic [NCH-1:0]    req_any;
    logic              mem_read_d;
    logic              mem_write_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [LINE_W-1:0] mem_wdata_d;
    logic [NCH-1:0]    resp_d;
    logic [LINE_W-1:0] resp_rdata_d;

    assign req_any = req_read | req_write;

    lc3b_rr_picker #(
        .NCH (NCH)
    ) u_picker (
        .req        (req_any),
        .last_grant (last_grant_q),
        .mode       (MODE),
        .grant_c    (pick_grant),
        .any_c      (pick_any)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next register values. mem_write doubles as the latched
    // op_write flag; resp_rdata doubles as the captured read line, so both
    // it and resp fall back to zero on every cycle that is not ARB_DONE.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        mem_read_d    = mem_read;
        mem_write_d   = mem_write;
        mem_address_d = mem_address;
        mem_wdata_d   = mem_wdata;
        resp_d        = '0;
        resp_rdata_d  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d       = ARB_BUSY;
                    grant_d       = pick_grant;
                    mem_write_d   = req_write[pick_grant];
                    mem_read_d    = !req_write[pick_grant];
                    mem_address_d = req_addr[pick_grant];
                    mem_wdata_d   = req_wdata[pick_grant];
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    state_d          = ARB_DONE;
                    mem_read_d       = 1'b0;
                    mem_write_d      = 1'b0;
                    resp_d[grant_q]  = 1'b1;
                    resp_rdata_d     = mem_rdata;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                if (MODE == ARB_RR) begin
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Transaction and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= '0;
            last_grant_q <= GW'(NCH - 1);
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            resp         <= '0;
            resp_rdata   <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            mem_address  <= mem_address_d;
            mem_wdata    <= mem_wdata_d;
            resp         <= resp_d;
            resp_rdata   <= resp_rdata_d;
        end
    end

endmodule
